// File: rtl/ula_if.sv
// rtl/ula_if.sv - operand/opcode/result bundle for the ula compute block
//
// Groups the datapath signals of one ula instance.
//   master : upstream control, drives a, b, opcode and reads result/flags
//   slave  : the ula side, reads a, b, opcode and drives result/flags
// Signals:
//   a, b    WIDTH  operands
//   opcode  3      operation select
//   s       WIDTH  registered result
//   cout    1      registered carry/borrow
//   zero    1      registered zero flag
//   neg     1      registered sign flag
//   ovf     1      registered signed-overflow flag

interface ula_if #(
  parameter int WIDTH = 8
);

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       opcode;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             zero;
  logic             neg;
  logic             ovf;

  modport master (
    output a,
    output b,
    output opcode,
    input  s,
    input  cout,
    input  zero,
    input  neg,
    input  ovf
  );

  modport slave (
    input  a,
    input  b,
    input  opcode,
    output s,
    output cout,
    output zero,
    output neg,
    output ovf
  );

endinterface

// File: rtl/ula.sv
// rtl/ula.sv - 8-bit arithmetic/logic unit with registered result and flags
//
// A combinational datapath evaluates the selected operation on a and b; the
// result and status flags are captured on every rising clk edge (latency 1,
// one new operation accepted per cycle, no handshake).
// Ports (positional order is fixed and relied on by older benches):
//   a       in   WIDTH  operand A
//   b       in   WIDTH  operand B (low bits give the shift amount for shifts)
//   opcode  in   3      000 ADD, 001 SUB, 010 AND, 011 OR,
//                       100 XOR, 101 NOT, 110 SHL, 111 SHR
//   s       out  WIDTH  registered result
//   clk     in   1      rising-edge clock
//   rst_n   in   1      asynchronous active-low reset
//   cout    out  1      registered carry (ADD), borrow (SUB), shifted-out bit
//   zero    out  1      registered s == 0
//   neg     out  1      registered s[MSB]
//   ovf     out  1      registered two's-complement overflow (ADD/SUB only)

module ula #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       opcode,
  output logic [WIDTH-1:0] s,
  input  logic             clk,
  input  logic             rst_n,
  output logic             cout,
  output logic             zero,
  output logic             neg,
  output logic             ovf
);

  localparam int MSB = WIDTH - 1;
  localparam int SHW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_SHR = 3'b111;

  // Arithmetic is done one bit wider so the extra bit is the carry/borrow.
  logic [WIDTH:0]   add_w;
  logic [WIDTH:0]   sub_w;
  // Shifts carry a guard bit on the side the data leaves from: after the
  // shift that bit holds the last bit pushed out, and stays 0 for amount 0.
  logic [WIDTH:0]   shl_w;
  logic [WIDTH:0]   shr_w;
  logic [SHW-1:0]   amt;

  logic [WIDTH-1:0] r_nxt;
  logic             c_nxt;
  logic             v_nxt;
  logic             upd;

  assign amt   = b[SHW-1:0];
  assign add_w = {1'b0, a} + {1'b0, b};
  assign sub_w = {1'b0, a} - {1'b0, b};
  assign shl_w = {1'b0, a} << amt;
  assign shr_w = {a, 1'b0} >> amt;

  always_comb begin
    r_nxt = '0;
    c_nxt = 1'b0;
    v_nxt = 1'b0;
    upd   = 1'b1;
    case (opcode)
      OP_ADD: begin
        r_nxt = add_w[WIDTH-1:0];
        c_nxt = add_w[WIDTH];
        v_nxt = (a[MSB] == b[MSB]) && (add_w[MSB] != a[MSB]);
      end
      OP_SUB: begin
        r_nxt = sub_w[WIDTH-1:0];
        c_nxt = sub_w[WIDTH];
        v_nxt = (a[MSB] != b[MSB]) && (sub_w[MSB] != a[MSB]);
      end
      OP_AND: r_nxt = a & b;
      OP_OR:  r_nxt = a | b;
      OP_XOR: r_nxt = a ^ b;
      OP_NOT: r_nxt = ~a;
      OP_SHL: begin
        r_nxt = shl_w[WIDTH-1:0];
        c_nxt = shl_w[WIDTH];
      end
      OP_SHR: begin
        r_nxt = shr_w[WIDTH:1];
        c_nxt = shr_w[0];
      end
      // Only reachable when opcode carries X/Z in a four-state simulator:
      // the registers keep their contents. All binary codes are listed
      // above, so synthesis sees this branch as unreachable.
      default: upd = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s    <= '0;
      cout <= 1'b0;
      zero <= 1'b1;
      neg  <= 1'b0;
      ovf  <= 1'b0;
    end else if (upd) begin
      s    <= r_nxt;
      cout <= c_nxt;
      zero <= (r_nxt == '0);
      neg  <= r_nxt[MSB];
      ovf  <= v_nxt;
    end
  end

endmodule

// File: tb/tb_ula.sv
// tb/tb_ula.sv - directed self-checking bench for ula

module tb_ula;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  ula_if #(.WIDTH(8)) u_if ();

  ula #(.WIDTH(8)) dut (
    .a      (u_if.a),
    .b      (u_if.b),
    .opcode (u_if.opcode),
    .s      (u_if.s),
    .clk    (clk),
    .rst_n  (rst_n),
    .cout   (u_if.cout),
    .zero   (u_if.zero),
    .neg    (u_if.neg),
    .ovf    (u_if.ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%02h expected=0x%02h", tag, obs, exp);
    end
  endtask

  // s, cout, zero, neg, ovf against expected values
  task automatic check_all(input string tag, input logic [7:0] es,
                           input logic ec, input logic ez, input logic en, input logic ev);
    check({tag, ".s"},    u_if.s,           es);
    check({tag, ".cout"}, {7'd0, u_if.cout}, {7'd0, ec});
    check({tag, ".zero"}, {7'd0, u_if.zero}, {7'd0, ez});
    check({tag, ".neg"},  {7'd0, u_if.neg},  {7'd0, en});
    check({tag, ".ovf"},  {7'd0, u_if.ovf},  {7'd0, ev});
  endtask

  // Present an operation at the falling edge, sample 1ns after the rising edge.
  task automatic apply(input logic [7:0] av, input logic [7:0] bv, input logic [2:0] op);
    @(negedge clk);
    u_if.a      = av;
    u_if.b      = bv;
    u_if.opcode = op;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    errors      = 0;
    checks      = 0;
    rst_n       = 1'b0;
    u_if.a      = 8'h00;
    u_if.b      = 8'h00;
    u_if.opcode = 3'b000;

    // Reset state held across edges
    repeat (2) @(posedge clk);
    #1;
    check_all("reset_idle", 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);

    // Release, produce a nonzero result, then assert reset between edges
    @(negedge clk);
    rst_n = 1'b1;
    apply(8'h33, 8'h44, 3'b000);
    check_all("pre_reset", 8'h77, 1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_all("async_reset", 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // First capture after release; then SUB of the same operands
    apply(8'd5, 8'd10, 3'b000);
    check_all("add_5_10", 8'h0F, 1'b0, 1'b0, 1'b0, 1'b0);
    apply(8'd5, 8'd10, 3'b001);
    check_all("sub_5_10", 8'hFB, 1'b1, 1'b0, 1'b1, 1'b0);

    // Overflow and carry boundaries
    apply(8'h7F, 8'h01, 3'b000);
    check_all("add_7f_01", 8'h80, 1'b0, 1'b0, 1'b1, 1'b1);
    apply(8'hFF, 8'h01, 3'b000);
    check_all("add_ff_01", 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    apply(8'h80, 8'h01, 3'b001);
    check_all("sub_80_01", 8'h7F, 1'b0, 1'b0, 1'b0, 1'b1);
    apply(8'h40, 8'h40, 3'b001);
    check_all("sub_equal", 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);

    // Logic ops on a=F0, b=3C; flags from a preceding carry must clear
    apply(8'hFF, 8'h01, 3'b000);
    apply(8'hF0, 8'h3C, 3'b010);
    check_all("and", 8'h30, 1'b0, 1'b0, 1'b0, 1'b0);
    apply(8'hF0, 8'h3C, 3'b011);
    check_all("or", 8'hFC, 1'b0, 1'b0, 1'b1, 1'b0);
    apply(8'hF0, 8'h3C, 3'b100);
    check_all("xor", 8'hCC, 1'b0, 1'b0, 1'b1, 1'b0);
    apply(8'hF0, 8'h3C, 3'b101);
    check_all("not", 8'h0F, 1'b0, 1'b0, 1'b0, 1'b0);
    apply(8'hFF, 8'h55, 3'b101);
    check_all("not_ff", 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);

    // Shifts
    apply(8'h81, 8'd1, 3'b110);
    check_all("shl_1", 8'h02, 1'b1, 1'b0, 1'b0, 1'b0);
    apply(8'h81, 8'd1, 3'b111);
    check_all("shr_1", 8'h40, 1'b1, 1'b0, 1'b0, 1'b0);
    apply(8'h81, 8'd0, 3'b110);
    check_all("shl_0", 8'h81, 1'b0, 1'b0, 1'b1, 1'b0);
    apply(8'h81, 8'd0, 3'b111);
    check_all("shr_0", 8'h81, 1'b0, 1'b0, 1'b1, 1'b0);
    apply(8'h01, 8'd1, 3'b111);
    check_all("shr_to_zero", 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    apply(8'h03, 8'd7, 3'b110);
    check_all("shl_7", 8'h80, 1'b1, 1'b0, 1'b1, 1'b0);
    apply(8'hA5, 8'hFA, 3'b111);
    check_all("shr_2_upper_b", 8'h29, 1'b0, 1'b0, 1'b0, 1'b0);

    // Hold: operand changes between edges do not reach the outputs
    apply(8'h12, 8'h34, 3'b000);
    check_all("hold_base", 8'h46, 1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    u_if.a      = 8'hFF;
    u_if.b      = 8'hFF;
    u_if.opcode = 3'b001;
    #2;
    check_all("hold_midcycle", 8'h46, 1'b0, 1'b0, 1'b0, 1'b0);

    // Back-to-back operations, one result per edge
    apply(8'h10, 8'h20, 3'b000);
    check_all("b2b_add", 8'h30, 1'b0, 1'b0, 1'b0, 1'b0);
    apply(8'h10, 8'h20, 3'b001);
    check_all("b2b_sub", 8'hF0, 1'b1, 1'b0, 1'b1, 1'b0);
    apply(8'h10, 8'h20, 3'b011);
    check_all("b2b_or", 8'h30, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
